// File: rtl/move_sequencer.sv
// Player movement sequencer: iterative tile divide, two shared-ROM wall
// lookups (current then adjacent tile), then at most one STEP move.
// Ports:
//   clk, rst                    clock and async active-high reset
//   tick, dir, home, level      move request, one-hot direction, return-home, level
//   tile_w, tile_h, num_rows,   active level geometry and collision margin
//   num_cols, wall_margin
//   rom_req, rom_row, rom_col,  shared wall-ROM port; walls arrive the cycle
//   rom_walls                   after rom_req
//   pos_x, pos_y                player position
//   cur_row, cur_col            tile of the last evaluation
//   busy, move_done             sequence in progress / one-cycle completion pulse
module move_sequencer #(
  parameter int STEP    = 2,
  parameter int SPRITE  = 10,
  parameter int START_X = 394,
  parameter int START_Y = 41
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [3:0]  dir,
  input  logic        home,
  input  logic [1:0]  level,
  input  logic [9:0]  tile_w,
  input  logic [9:0]  tile_h,
  input  logic [4:0]  num_rows,
  input  logic [4:0]  num_cols,
  input  logic [9:0]  wall_margin,
  output logic        rom_req,
  output logic [4:0]  rom_row,
  output logic [4:0]  rom_col,
  input  logic [3:0]  rom_walls,
  output logic [10:0] pos_x,
  output logic [10:0] pos_y,
  output logic [4:0]  cur_row,
  output logic [4:0]  cur_col,
  output logic        busy,
  output logic        move_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIV,
    S_RQC,
    S_CPC,
    S_RQA,
    S_CPA,
    S_APPLY
  } state_t;

  localparam logic [11:0] STEP12 = 12'(STEP);
  localparam logic [11:0] SPR12  = 12'(SPRITE);
  localparam logic [11:0] MAX12  = 12'd2047;
  localparam logic [10:0] HOME_X = 11'(START_X);
  localparam logic [10:0] HOME_Y = 11'(START_Y);
  localparam logic [3:0]  DIV_LAST = 4'd10;

  localparam logic [3:0] D_UP = 4'b0001;
  localparam logic [3:0] D_LT = 4'b0010;
  localparam logic [3:0] D_RT = 4'b0100;
  localparam logic [3:0] D_DN = 4'b1000;

  state_t state, state_n;

  logic [1:0]  prev_level;
  logic [3:0]  d;
  logic [3:0]  cnt;
  logic [10:0] qx, qy;
  logic [9:0]  rx, ry;
  logic [3:0]  wc, wa;

  logic abort;
  logic start_ok;

  assign abort    = home | (level != prev_level);
  assign start_ok = tick & (tile_w != 10'd0) & (tile_h != 10'd0);

  assign busy    = (state != S_IDLE);
  assign rom_req = (state == S_RQC) | (state == S_RQA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (abort) begin
      state_n = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (start_ok) state_n = S_DIV;
        S_DIV:   if (cnt == DIV_LAST) state_n = S_RQC;
        S_RQC:   state_n = S_CPC;
        S_CPC:   state_n = S_RQA;
        S_RQA:   state_n = S_CPA;
        S_CPA:   state_n = S_APPLY;
        S_APPLY: state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Restoring divide step: shift the next dividend bit into the
  // remainder, subtract when it fits, shift the outcome into the quotient.
  logic [10:0] sx, sy, dfx, dfy;
  logic        gex, gey;
  logic [10:0] qx_n, qy_n;
  logic [9:0]  rx_n, ry_n;

  always_comb begin
    sx   = {rx, qx[10]};
    sy   = {ry, qy[10]};
    gex  = (sx >= {1'b0, tile_w});
    gey  = (sy >= {1'b0, tile_h});
    dfx  = sx - {1'b0, tile_w};
    dfy  = sy - {1'b0, tile_h};
    rx_n = gex ? dfx[9:0] : sx[9:0];
    ry_n = gey ? dfy[9:0] : sy[9:0];
    qx_n = {qx[9:0], gex};
    qy_n = {qy[9:0], gey};
  end

  // Neighbour in the requested direction, clamped at the maze edge.
  // Anything other than a single direction bit stays on the current tile.
  logic [4:0] adj_row, adj_col;

  always_comb begin
    adj_row = cur_row;
    adj_col = cur_col;
    case (d)
      D_UP: if (cur_row != 5'd0) adj_row = cur_row - 5'd1;
      D_DN: if (({1'b0, cur_row} + 6'd1) < {1'b0, num_rows})
              adj_row = cur_row + 5'd1;
      D_LT: if (cur_col != 5'd0) adj_col = cur_col - 5'd1;
      D_RT: if (({1'b0, cur_col} + 6'd1) < {1'b0, num_cols})
              adj_col = cur_col + 5'd1;
      default: ;
    endcase
  end

  logic [11:0] m12, tw12, th12, lim_x, lim_y, xin12, yin12;
  logic        blk_up, blk_dn, blk_lt, blk_rt;

  always_comb begin
    m12   = {2'b00, wall_margin};
    tw12  = {2'b00, tile_w};
    th12  = {2'b00, tile_h};
    xin12 = {2'b00, rx};
    yin12 = {2'b00, ry};
    lim_x = (tw12 > m12) ? (tw12 - m12) : 12'd0;
    lim_y = (th12 > m12) ? (th12 - m12) : 12'd0;
    blk_up = (wc[3] | wa[2]) & (yin12 <= m12);
    blk_dn = (wc[2] | wa[3]) & ((yin12 + SPR12) >= lim_y);
    blk_lt = (wc[1] | wa[0]) & (xin12 <= m12);
    blk_rt = (wc[0] | wa[1]) & ((xin12 + SPR12) >= lim_x);
  end

  logic [11:0] px12, py12, sum_x, sum_y;
  logic [10:0] nx, ny;

  always_comb begin
    px12  = {1'b0, pos_x};
    py12  = {1'b0, pos_y};
    sum_x = px12 + STEP12;
    sum_y = py12 + STEP12;
    nx    = pos_x;
    ny    = pos_y;
    case (d)
      D_UP: if (!blk_up)
              ny = (py12 >= STEP12) ? 11'(py12 - STEP12) : 11'd0;
      D_DN: if (!blk_dn)
              ny = (sum_y > MAX12) ? 11'd2047 : sum_y[10:0];
      D_LT: if (!blk_lt)
              nx = (px12 >= STEP12) ? 11'(px12 - STEP12) : 11'd0;
      D_RT: if (!blk_rt)
              nx = (sum_x > MAX12) ? 11'd2047 : sum_x[10:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_x      <= HOME_X;
      pos_y      <= HOME_Y;
      prev_level <= 2'd0;
      d          <= 4'd0;
      cnt        <= 4'd0;
      qx         <= 11'd0;
      qy         <= 11'd0;
      rx         <= 10'd0;
      ry         <= 10'd0;
      wc         <= 4'd0;
      wa         <= 4'd0;
      rom_row    <= 5'd0;
      rom_col    <= 5'd0;
      cur_row    <= 5'd0;
      cur_col    <= 5'd0;
      move_done  <= 1'b0;
    end else begin
      move_done <= 1'b0;
      if (abort) begin
        pos_x      <= HOME_X;
        pos_y      <= HOME_Y;
        prev_level <= level;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start_ok) begin
              d   <= dir;
              qx  <= pos_x;
              qy  <= pos_y;
              rx  <= 10'd0;
              ry  <= 10'd0;
              cnt <= 4'd0;
            end
          end
          S_DIV: begin
            qx  <= qx_n;
            qy  <= qy_n;
            rx  <= rx_n;
            ry  <= ry_n;
            cnt <= cnt + 4'd1;
            if (cnt == DIV_LAST) begin
              cur_row <= qy_n[4:0];
              cur_col <= qx_n[4:0];
              rom_row <= qy_n[4:0];
              rom_col <= qx_n[4:0];
            end
          end
          S_RQC: ;
          S_CPC: begin
            wc      <= rom_walls;
            rom_row <= adj_row;
            rom_col <= adj_col;
          end
          S_RQA: ;
          S_CPA: wa <= rom_walls;
          S_APPLY: begin
            pos_x     <= nx;
            pos_y     <= ny;
            move_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
